mdu_iter: RTL

- Iterative RV32M multiply/divide unit: the execute-side producer for the register-file write port.
- Consumes rs1/rs2 read data plus a destination address, computes over multiple cycles, then emits one registered write (wen/waddr/wdata) for the rf write port.
- Core stalls on o_busy.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_div_step.sv | 21 ++
 rtl/mdu_iter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam int unsigned ITER_CNT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module mdu_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] divisor_i,
  input  logic        bit_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [32:0] shifted;
  logic [31:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    // When the divisor fits, the difference is below 2^32, so 32-bit wraparound is exact.
    diff    = shifted[31:0] - divisor_i;
    rem_o   = q_bit_o ? diff : shifted[31:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit; emits one registered rf write per accepted request.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter bit FAST_MUL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd_waddr,
  output logic        o_busy,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  // Request decode.
  logic        in_is_mul, a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] special_res, fast_res;
  logic [63:0] a64, b64, fast_prod;

  always_comb begin
    in_is_mul = ~i_funct3[2];
    a_signed  = (i_funct3 == MDU_MULH) || (i_funct3 == MDU_MULHSU) ||
                (i_funct3 == MDU_DIV)  || (i_funct3 == MDU_REM);
    b_signed  = (i_funct3 == MDU_MULH) || (i_funct3 == MDU_DIV) || (i_funct3 == MDU_REM);
    sa        = a_signed & i_rs1[31];
    sb        = b_signed & i_rs2[31];
    mag_a     = sa ? (~i_rs1 + 32'd1) : i_rs1;
    mag_b     = sb ? (~i_rs2 + 32'd1) : i_rs2;

    div_zero  = ~in_is_mul && (i_rs2 == 32'd0);
    div_ovf   = ((i_funct3 == MDU_DIV) || (i_funct3 == MDU_REM)) &&
                (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    if (div_zero) begin
      special_res = i_funct3[1] ? i_rs1 : 32'hFFFF_FFFF;
    end else begin
      special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Low 64 bits of the 33x33 signed product are exact for every RV32M operand pair.
    a64       = {{32{sa}}, i_rs1};
    b64       = {{32{sb}}, i_rs2};
    fast_prod = a64 * b64;
    fast_res  = (i_funct3 == MDU_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end

  // One iteration of either algorithm, plus the sign-corrected result it would yield.
  logic [31:0] div_rem;
  logic        div_q;
  logic [32:0] mul_sum;
  logic [63:0] step_acc, prod_s;
  logic [31:0] quot, rem, calc_res;

  mdu_div_step u_div_step (
    .rem_i     (acc_q[63:32]),
    .divisor_i (opb_q),
    .bit_i     (acc_q[31]),
    .rem_o     (div_rem),
    .q_bit_o   (div_q)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    step_acc = funct3_q[2] ? {div_rem, acc_q[30:0], div_q} : {mul_sum, acc_q[31:1]};
    prod_s   = neg_q ? -step_acc : step_acc;
    quot     = neg_q ? -step_acc[31:0] : step_acc[31:0];
    rem      = rneg_q ? -step_acc[63:32] : step_acc[63:32];
    if (funct3_q[2]) begin
      calc_res = funct3_q[1] ? rem : quot;
    end else begin
      calc_res = (funct3_q == MDU_MUL) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    wen_d    = 1'b0;
    waddr_d  = 5'd0;
    wdata_d  = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          funct3_d = i_funct3;
          rd_d     = i_rd_waddr;
          acc_d    = {32'd0, mag_a};
          opb_d    = mag_b;
          neg_d    = sa ^ sb;
          rneg_d   = sa & ~in_is_mul;
          cnt_d    = 5'd0;
          if (div_zero || div_ovf) begin
            state_d = StDone;
            wen_d   = 1'b1;
            waddr_d = i_rd_waddr;
            wdata_d = special_res;
          end else if (in_is_mul && FAST_MUL) begin
            state_d = StDone;
            wen_d   = 1'b1;
            waddr_d = i_rd_waddr;
            wdata_d = fast_res;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_CNT - 1)) begin
          state_d = StDone;
          wen_d   = 1'b1;
          waddr_d = rd_q;
          wdata_d = calc_res;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      funct3_q <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_rd_wen   = wen_q;
  assign o_rd_waddr = waddr_q;
  assign o_rd_wdata = wdata_q;

endmodule
